// File: rtl/fpu_move_wb.sv
// Move-result writeback stage: 2-entry in-order FIFO toward the register files.
// Optional retire counter enabled by FPU_MOVE_WB_RETIRE_CNT_EN.
module fpu_move_wb #(
    parameter int Std = 31
) (
    input  logic         clk,
    input  logic         rst_l,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   opcode,
    input  logic [Std:0] move_data,
    input  logic [4:0]   rd_addr,
    output logic         wb_valid,
    input  logic         wb_ready,
    output logic [Std:0] wb_data,
    output logic [4:0]   wb_addr,
    output logic         wb_int_sel,
`ifdef FPU_MOVE_WB_RETIRE_CNT_EN
    output logic [15:0]  retire_cnt,
`endif
    output logic         drop_pulse
);

    logic [Std:0] data_q [2];
    logic [4:0]   addr_q [2];
    logic         sel_q  [2];
    logic [1:0]   count;
    logic         wr_ptr;
    logic         rd_ptr;

    logic accept;
    logic push;
    logic drop;
    logic pop;

    assign in_ready = (count != 2'd2);
    assign accept   = in_valid & in_ready;
    assign push     = accept & (opcode != 2'b00);
    assign drop     = accept & (opcode == 2'b00);
    assign wb_valid = (count != 2'd0);
    assign pop      = wb_valid & wb_ready;

    // Idle outputs are forced to zero rather than exposing stale storage.
    assign wb_data    = wb_valid ? data_q[rd_ptr] : '0;
    assign wb_addr    = wb_valid ? addr_q[rd_ptr] : '0;
    assign wb_int_sel = wb_valid ? sel_q[rd_ptr]  : 1'b0;

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            count      <= 2'd0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            drop_pulse <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                addr_q[i] <= '0;
                sel_q[i]  <= 1'b0;
            end
        end else begin
            drop_pulse <= drop;
            if (push) begin
                data_q[wr_ptr] <= move_data;
                addr_q[wr_ptr] <= rd_addr;
                sel_q[wr_ptr]  <= opcode[0];
                wr_ptr         <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

`ifdef FPU_MOVE_WB_RETIRE_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            retire_cnt <= 16'd0;
        end else if (pop) begin
            retire_cnt <= retire_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fpu_move_wb.sv
// Directed bench for fpu_move_wb: vector table plus backpressure,
// drop, reset and retire-counter sequences.
module tb_fpu_move_wb;

    logic        clk = 1'b0;
    logic        rst_l;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  opcode;
    logic [31:0] move_data;
    logic [4:0]  rd_addr;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_addr;
    logic        wb_int_sel;
    logic        drop_pulse;
`ifdef FPU_MOVE_WB_RETIRE_CNT_EN
    logic [15:0] retire_cnt;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    fpu_move_wb #(.Std(31)) dut (
        .clk        (clk),
        .rst_l      (rst_l),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .opcode     (opcode),
        .move_data  (move_data),
        .rd_addr    (rd_addr),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_data    (wb_data),
        .wb_addr    (wb_addr),
        .wb_int_sel (wb_int_sel),
`ifdef FPU_MOVE_WB_RETIRE_CNT_EN
        .retire_cnt (retire_cnt),
`endif
        .drop_pulse (drop_pulse)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        exp_valid;
        logic        exp_sel;
        logic        exp_drop;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Advance one edge; inputs are driven and outputs sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op,
                         input logic [31:0] d, input logic [4:0] rd);
        in_valid  = v;
        opcode    = op;
        move_data = d;
        rd_addr   = rd;
    endtask

    initial begin
        vecs[0] = '{2'b01, 32'h3F80_0000, 5'd5,  1'b1, 1'b1, 1'b0};
        vecs[1] = '{2'b10, 32'h4049_0FDB, 5'd12, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{2'b11, 32'hC000_0000, 5'd31, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{2'b00, 32'hDEAD_BEEF, 5'd7,  1'b0, 1'b0, 1'b1};
        vecs[4] = '{2'b10, 32'hFFFF_FFFF, 5'd0,  1'b1, 1'b0, 1'b0};
        vecs[5] = '{2'b01, 32'h0000_0001, 5'd1,  1'b1, 1'b1, 1'b0};

        rst_l = 1'b0;
        wb_ready = 1'b1;
        drive(1'b1, 2'b01, 32'hAAAA_AAAA, 5'd3);
        step();
        step();
        rst_l = 1'b1;
        drive(1'b0, 2'b00, 32'h0, 5'd0);
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_wb_addr", {27'd0, wb_addr}, 32'd0);
        chk("rst_int_sel", {31'd0, wb_int_sel}, 32'd0);
        chk("rst_drop", {31'd0, drop_pulse}, 32'd0);

        // Popping while empty must not underflow.
        step();
        chk("empty_pop_valid", {31'd0, wb_valid}, 32'd0);
        chk("empty_pop_ready", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 6; i++) begin
            drive(1'b1, vecs[i].op, vecs[i].data, vecs[i].rd);
            step();
            drive(1'b0, 2'b11, 32'h1234_5678, 5'd9);
            chk($sformatf("v%0d_valid", i), {31'd0, wb_valid},
                {31'd0, vecs[i].exp_valid});
            chk($sformatf("v%0d_data", i), wb_data,
                vecs[i].exp_valid ? vecs[i].data : 32'd0);
            chk($sformatf("v%0d_addr", i), {27'd0, wb_addr},
                vecs[i].exp_valid ? {27'd0, vecs[i].rd} : 32'd0);
            chk($sformatf("v%0d_sel", i), {31'd0, wb_int_sel},
                {31'd0, vecs[i].exp_sel});
            chk($sformatf("v%0d_drop", i), {31'd0, drop_pulse},
                {31'd0, vecs[i].exp_drop});
            step();
            chk($sformatf("v%0d_empty", i), {31'd0, wb_valid}, 32'd0);
            chk($sformatf("v%0d_zero", i), wb_data, 32'd0);
            chk($sformatf("v%0d_drop_off", i), {31'd0, drop_pulse}, 32'd0);
        end

        // Backpressure: A and B fill, C waits, then all drain in order.
        wb_ready = 1'b0;
        drive(1'b1, 2'b01, 32'hAAAA_0001, 5'd10);
        step();
        chk("bp_a_ready", {31'd0, in_ready}, 32'd1);
        chk("bp_a_head", wb_data, 32'hAAAA_0001);
        drive(1'b1, 2'b10, 32'hBBBB_0002, 5'd11);
        step();
        chk("bp_full", {31'd0, in_ready}, 32'd0);
        chk("bp_hold_a", wb_data, 32'hAAAA_0001);
        drive(1'b1, 2'b01, 32'hCCCC_0003, 5'd12);
        step();
        chk("bp_c_held", {31'd0, in_ready}, 32'd0);
        chk("bp_stable_a", wb_data, 32'hAAAA_0001);
        chk("bp_stable_addr", {27'd0, wb_addr}, 32'd10);
        wb_ready = 1'b1;
        step();
        chk("bp_pop_a_ready", {31'd0, in_ready}, 32'd1);
        chk("bp_head_b", wb_data, 32'hBBBB_0002);
        chk("bp_b_sel", {31'd0, wb_int_sel}, 32'd0);
        step();
        drive(1'b0, 2'b00, 32'h0, 5'd0);
        chk("bp_head_c", wb_data, 32'hCCCC_0003);
        chk("bp_c_addr", {27'd0, wb_addr}, 32'd12);
        chk("bp_c_valid", {31'd0, wb_valid}, 32'd1);
        step();
        chk("bp_drained", {31'd0, wb_valid}, 32'd0);

        // Drop while one entry is held leaves the entry untouched.
        wb_ready = 1'b0;
        drive(1'b1, 2'b10, 32'h1111_2222, 5'd4);
        step();
        drive(1'b1, 2'b00, 32'h9999_9999, 5'd8);
        step();
        drive(1'b0, 2'b00, 32'h0, 5'd0);
        chk("dq_drop", {31'd0, drop_pulse}, 32'd1);
        chk("dq_ready", {31'd0, in_ready}, 32'd1);
        chk("dq_head", wb_data, 32'h1111_2222);
        step();
        chk("dq_drop_once", {31'd0, drop_pulse}, 32'd0);
        chk("dq_head_kept", wb_data, 32'h1111_2222);

        // Reset with two entries buffered and a push on the reset edge.
        drive(1'b1, 2'b01, 32'h5555_5555, 5'd6);
        step();
        chk("ro_full", {31'd0, in_ready}, 32'd0);
        rst_l = 1'b0;
        drive(1'b1, 2'b01, 32'h7777_7777, 5'd2);
        step();
        rst_l = 1'b1;
        drive(1'b0, 2'b00, 32'h0, 5'd0);
        chk("ro_valid", {31'd0, wb_valid}, 32'd0);
        chk("ro_ready", {31'd0, in_ready}, 32'd1);
        chk("ro_data", wb_data, 32'd0);
        wb_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("ro_stale%0d", i), {31'd0, wb_valid}, 32'd0);
        end

`ifdef FPU_MOVE_WB_RETIRE_CNT_EN
        chk("rc_reset", {16'd0, retire_cnt}, 32'd0);
        drive(1'b1, 2'b01, 32'h0000_00AA, 5'd1);
        for (int i = 0; i < 65536; i++) step();
        chk("rc_ffff", {16'd0, retire_cnt}, 32'h0000_FFFF);
        step();
        chk("rc_wrap", {16'd0, retire_cnt}, 32'd0);
        drive(1'b0, 2'b00, 32'h0, 5'd0);
        step();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fpu_move_wb.md
FPU_MOVE_WB -- requirements
Module: fpu_move_wb

Interface
REQ-001 SHALL have parameter: Std, default 31, MSB index of the move datapath (width Std+1).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst_l  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port: in_valid  input  1  move result present from the upstream move stage.
REQ-005 SHALL have port: in_ready  output  1  stage can accept a result this cycle.
REQ-006 SHALL have port: opcode  input  2  move opcode; bit0 = FP->integer move, bit1 = integer->FP move.
REQ-007 SHALL have port: move_data  input  Std+1  move result payload.
REQ-008 SHALL have port: rd_addr  input  5  destination register index.
REQ-009 SHALL have port: wb_valid  output  1  writeback entry available.
REQ-010 SHALL have port: wb_ready  input  1  register file accepts the entry.
REQ-011 SHALL have port: wb_data  output  Std+1  writeback payload.
REQ-012 SHALL have port: wb_addr  output  5  writeback register index.
REQ-013 SHALL have port: wb_int_sel  output  1  1 = integer file, 0 = FP file.
REQ-014 SHALL have port: drop_pulse  output  1  one-cycle pulse on a discarded opcode 2'b00 transfer.

Function
REQ-015 SHALL buffer results in a 2-entry in-order FIFO: {data, addr, int_sel}, 2-bit occupancy count, 1-bit read and write pointers that wrap 1->0.
REQ-016 SHALL drive in_ready = (count != 2), from registered state only, with no combinational path from wb_ready.
REQ-017 SHALL define a push as in_valid & in_ready & (opcode != 2'b00).
REQ-018 SHALL handle in_valid & in_ready & opcode == 2'b00 by consuming it without storage and asserting drop_pulse on the next cycle.
REQ-019 SHALL set int_sel = opcode[0]; when both bits are set, opcode[0] takes priority (int_sel = 1).
REQ-020 SHALL drive wb_valid = (count != 0), with wb_data/wb_addr/wb_int_sel taken from the head entry.
REQ-021 SHALL drive wb_data, wb_addr and wb_int_sel to zero when count == 0.
REQ-022 SHALL define a pop as wb_valid & wb_ready; wb_data SHALL hold stable while wb_valid=1 and wb_ready=0.
REQ-023 SHALL have a latency of 1 cycle: a push at edge N makes the entry visible at wb_* after edge N; no flow-through.
REQ-024 SHALL handle a simultaneous push and pop at count 1 by leaving count = 1 and presenting the new entry next, preserving order.
REQ-025 SHALL never push at count 2 (in_ready=0); a pop at count 2 SHALL raise in_ready the following cycle.
REQ-026 SHALL ignore a pop at count 0 (wb_valid=0), and SHALL not underflow.
REQ-027 SHALL ignore opcode, move_data and rd_addr whenever in_valid=0.

Reset
REQ-028 SHALL, while rst_l=0 at a clock edge, set count=0, both pointers=0, all entry storage=0 and drop_pulse=0.
REQ-029 SHALL drive wb_valid=0, wb_data=0, wb_addr=0, wb_int_sel=0 and in_ready=1 in the cycle after reset is sampled.
REQ-030 SHALL discard buffered entries on reset mid-operation, with no writeback issued for them.
REQ-031 SHALL ignore a push coincident with asserted reset.

Configuration
REQ-032 SHALL, with macro FPU_MOVE_WB_RETIRE_CNT_EN defined, add output retire_cnt (16 bits) that increments by 1 per pop, wraps 16'hFFFF->0 and is cleared by reset.
REQ-033 SHALL, without FPU_MOVE_WB_RETIRE_CNT_EN, omit the retire_cnt port and counter logic; all other behaviour SHALL be identical.

Verification
REQ-034 SHALL cover single move: opcode=2'b01, data=32'h3F80_0000, rd=5, wb_ready=1 -> next cycle wb_valid=1, wb_data=32'h3F80_0000, wb_addr=5, wb_int_sel=1, and one cycle later empty.
REQ-035 SHALL cover backpressure: wb_ready=0, three back-to-back valids (A, B, C) -> A and B accepted, in_ready=0 at count 2, C held; release wb_ready -> A, B, C delivered in order.
REQ-036 SHALL cover drop: opcode=2'b00, in_valid=1 -> no wb_valid, drop_pulse=1 for exactly one cycle, count unchanged.
REQ-037 SHALL cover priority: opcode=2'b11, data=32'hC000_0000 -> wb_int_sel=1.
REQ-038 SHALL cover reset mid-op: two entries buffered, rst_l=0 for one cycle -> wb_valid=0, in_ready=1, wb_data=0; no stale entry later appears.
REQ-039 SHALL cover the counter: with FPU_MOVE_WB_RETIRE_CNT_EN defined, preload to 16'hFFFF via 65535 pops, one more pop -> retire_cnt=0.
